// File: rtl/mux_rr.sv
// Round-robin N-channel multiplexer with valid/ready on every input and a
// registered, backpressurable output stage. MODE 0 rotates strictly, MODE 1 skips idle channels.
module mux_rr #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int PW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [WIDTH*CHANNELS-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_out,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [PW-1:0]             chan_out,
  input  logic                      ready_in
);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    cand;
  logic             sel_vld;
  logic             load_en;
  logic             take;
  logic [WIDTH-1:0] sel_word;
  int               j;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    load_en = !valid_out || ready_in;
    sel     = ptr;
    sel_vld = 1'b0;
    cand    = ptr;
    j       = 0;

    if (MODE == 0) begin
      sel_vld = valid_in[ptr];
    end else begin
      // Walk offsets from far to near so the nearest valid channel wins.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= CHANNELS) j = j - CHANNELS;
        cand = PW'(j);
        if (valid_in[cand]) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
      end
    end

    sel_word = data_in[int'(sel)*WIDTH +: WIDTH];
    take     = load_en && sel_vld && !reset_L;

    ready_out = '0;
    if (take) ready_out[sel] = 1'b1;

    // Strict mode always advances; work-conserving mode only moves past a grant.
    if (MODE == 0 || sel_vld)
      ptr_nxt = (int'(sel) == CHANNELS - 1) ? '0 : sel + PW'(1);
    else
      ptr_nxt = ptr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      // NOTE: reset clears the output word too, so a stale word never leaks out.
      ptr       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      chan_out  <= '0;
    end else if (load_en) begin
      valid_out <= sel_vld;
      ptr       <= ptr_nxt;
      if (sel_vld) begin
        data_out <= sel_word;
        chan_out <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// Checks three mux_rr configurations (4ch strict, 4ch skip-idle, 3ch strict)
// every cycle against a rotation-order reference model.
module tb_mux_rr;

  typedef struct {
    int         ptr;
    logic [3:0] dout;
    logic       vout;
    int         cout;
  } mst_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  vin;
  logic        rin;

  logic [3:0] rdy_m0, rdy_m1;
  logic [2:0] rdy_c3;
  logic [3:0] dout_m0, dout_m1, dout_c3;
  logic       vout_m0, vout_m1, vout_c3;
  logic [1:0] cout_m0, cout_m1, cout_c3;

  int   checks = 0;
  int   errors = 0;
  bit   primed = 0;
  mst_t st [3];

  always #5 clk = ~clk;

  mux_rr #(.WIDTH(4), .CHANNELS(4), .MODE(0)) u_m0 (
    .clk(clk), .reset_L(rst), .data_in(din), .valid_in(vin), .ready_out(rdy_m0),
    .data_out(dout_m0), .valid_out(vout_m0), .chan_out(cout_m0), .ready_in(rin));

  mux_rr #(.WIDTH(4), .CHANNELS(4), .MODE(1)) u_m1 (
    .clk(clk), .reset_L(rst), .data_in(din), .valid_in(vin), .ready_out(rdy_m1),
    .data_out(dout_m1), .valid_out(vout_m1), .chan_out(cout_m1), .ready_in(rin));

  mux_rr #(.WIDTH(4), .CHANNELS(3), .MODE(0)) u_c3 (
    .clk(clk), .reset_L(rst), .data_in(din[11:0]), .valid_in(vin[2:0]), .ready_out(rdy_c3),
    .data_out(dout_c3), .valid_out(vout_c3), .chan_out(cout_c3), .ready_in(rin));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the specified behaviour: list channels in rotation order
  // starting at ptr, pick the grant from that list, then update the state.
  function automatic void model(input int mode, input int ch, input mst_t s,
                                input logic [15:0] d, input logic [3:0] v,
                                input logic r_in, input logic r,
                                output logic [3:0] rdy, output mst_t ns);
    int order[$];
    int g;
    rdy = '0;
    ns  = s;
    if (r) begin
      ns.ptr = 0; ns.dout = '0; ns.vout = 1'b0; ns.cout = 0;
      return;
    end
    if (s.vout && !r_in) return;
    for (int k = 0; k < ch; k++) order.push_back((s.ptr + k) % ch);
    g = -1;
    if (mode == 0) begin
      if (v[order[0]]) g = order[0];
    end else begin
      foreach (order[k]) if (g < 0 && v[order[k]]) g = order[k];
    end
    if (g >= 0) begin
      rdy[g]  = 1'b1;
      ns.dout = d[g*4 +: 4];
      ns.cout = g;
      ns.vout = 1'b1;
      ns.ptr  = (g + 1) % ch;
    end else begin
      ns.vout = 1'b0;
      ns.ptr  = (mode == 0) ? (s.ptr + 1) % ch : s.ptr;
    end
  endfunction

  task automatic step();
    mst_t       ns [3];
    logic [3:0] er;
    #1;
    model(0, 4, st[0], din, vin, rin, rst, er, ns[0]);
    check("m0.ready_out", rdy_m0, er);
    model(1, 4, st[1], din, vin, rin, rst, er, ns[1]);
    check("m1.ready_out", rdy_m1, er);
    model(0, 3, st[2], din, vin, rin, rst, er, ns[2]);
    check("c3.ready_out", {1'b0, rdy_c3}, er);
    if (primed) begin
      check("m0.data_out",  dout_m0, st[0].dout);
      check("m0.valid_out", vout_m0, st[0].vout);
      check("m0.chan_out",  cout_m0, st[0].cout);
      check("m1.data_out",  dout_m1, st[1].dout);
      check("m1.valid_out", vout_m1, st[1].vout);
      check("m1.chan_out",  cout_m1, st[1].cout);
      check("c3.data_out",  dout_c3, st[2].dout);
      check("c3.valid_out", vout_c3, st[2].vout);
      check("c3.chan_out",  cout_c3, st[2].cout);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) st[i] = ns[i];
    if (rst) primed = 1;
    @(negedge clk);
  endtask

  task automatic run(input logic r, input logic [3:0] v, input logic r_in, input int n);
    rst = r; vin = v; rin = r_in;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) st[i] = '{0, 4'd0, 1'b0, 0};
    din = 16'h4321;

    // Reset with every input asserted
    run(1'b1, 4'b1111, 1'b1, 2);
    // Full-rate rotation, all valid
    run(1'b0, 4'b1111, 1'b1, 5);
    // Sparse valid pattern: bubbles in strict mode
    run(1'b0, 4'b0101, 1'b1, 4);
    // Alternate channels valid, then none, then again
    run(1'b0, 4'b1010, 1'b1, 4);
    run(1'b0, 4'b0000, 1'b1, 2);
    run(1'b0, 4'b1010, 1'b1, 2);
    // Backpressure hold and release
    run(1'b0, 4'b1111, 1'b1, 3);
    run(1'b0, 4'b1111, 1'b0, 3);
    run(1'b0, 4'b1111, 1'b1, 3);
    // Reset mid-stream while stalled and while flowing
    run(1'b0, 4'b1111, 1'b0, 1);
    run(1'b1, 4'b1111, 1'b0, 1);
    run(1'b0, 4'b1111, 1'b1, 4);
    run(1'b1, 4'b1111, 1'b1, 1);
    run(1'b0, 4'b1111, 1'b1, 5);

    // Random traffic with occasional reset and backpressure
    for (int i = 0; i < 400; i++) begin
      din = 16'($urandom);
      vin = 4'($urandom_range(0, 15));
      rin = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
